tb_core_bus_router: RTL and testbench

// - Data-side interconnect between the zeroriscy core's data port and three TCDM-style targets.
//   - Target 0: HWPE peripheral port. Target 1: stack memory. Target 2: shared TCDM.
// - Decodes each core request, forwards it to exactly one target, and tracks outstanding grants.

---
 rtl/tb_core_bus_router_if.sv | 25 ++
 rtl/tb_core_bus_router.sv | 192 +++++++++++++++++++
 tb/tb_tb_core_bus_router.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/tb_core_bus_router_if.sv
// Core data-port bundle between the zeroriscy data master and the bus router.
// The core drives the request side; the router returns grant and response.
interface tb_core_bus_router_if;
    logic        data_req;
    logic        data_gnt;
    logic        data_rvalid;
    logic        data_we;
    logic [3:0]  data_be;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_err;

    // Handshake: a request is accepted in any cycle where data_req and data_gnt are
    // both high; exactly one data_rvalid pulse follows per accepted request, in order.
    modport master (
        output data_req, data_we, data_be, data_addr, data_wdata,
        input  data_gnt, data_rvalid, data_rdata, data_err
    );

    modport slave (
        input  data_req, data_we, data_be, data_addr, data_wdata,
        output data_gnt, data_rvalid, data_rdata, data_err
    );
endinterface

// File: rtl/tb_core_bus_router.sv
// Data-side router: steers core requests to HWPE / stack / TCDM targets or two local
// MMIO registers, and returns responses in grant order through an in-flight FIFO.
module tb_core_bus_router #(
    parameter int unsigned HWPE_ADDR_BASE_BIT = 20,
    parameter int unsigned MAX_OUTSTANDING    = 2,
    parameter logic [31:0] EXIT_ADDR          = 32'h8000_0000,
    parameter logic [31:0] PUTC_ADDR          = 32'h8000_0004
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    tb_core_bus_router_if.slave   core,
    output logic [2:0]            tgt_req_o,
    output logic [2:0][31:0]      tgt_add_o,
    output logic [2:0]            tgt_wen_o,
    output logic [2:0][3:0]       tgt_be_o,
    output logic [2:0][31:0]      tgt_data_o,
    input  logic [2:0]            tgt_gnt_i,
    input  logic [2:0][31:0]      tgt_r_data_i,
    input  logic [2:0]            tgt_r_valid_i,
    output logic                  exit_valid_o,
    output logic [31:0]           exit_code_o,
    output logic                  putc_valid_o,
    output logic [7:0]            putc_char_o,
    output logic                  protocol_err_o
);
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [1:0] SEL_LOCAL = 2'd3;

    logic [1:0]    sel;
    logic          is_exit;
    logic          is_putc;
    logic          stall;
    logic          empty;
    logic          push;
    logic          pop;
    logic          violation;
    logic [1:0]    head;

    logic [1:0]    fifo_q [MAX_OUTSTANDING];
    logic [1:0]    fifo_d [MAX_OUTSTANDING];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          protocol_err_q, protocol_err_d;
    logic          exit_valid_q, exit_valid_d;
    logic [31:0]   exit_code_q, exit_code_d;
    logic          putc_valid_q, putc_valid_d;
    logic [7:0]    putc_char_q, putc_char_d;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    // MMIO capture only applies to writes; reads of those addresses fall through to TCDM.
    always_comb begin
        is_exit = core.data_we && (core.data_addr == EXIT_ADDR);
        is_putc = core.data_we && (core.data_addr == PUTC_ADDR);
        if (is_exit || is_putc)                      sel = SEL_LOCAL;
        else if (core.data_addr[HWPE_ADDR_BASE_BIT]) sel = 2'd0;
        else if (core.data_addr[31:24] == 8'h00)     sel = 2'd1;
        else                                         sel = 2'd2;
    end

    assign stall = (count_q == CW'(MAX_OUTSTANDING));
    assign empty = (count_q == '0);
    assign head  = fifo_q[rd_ptr_q];

    always_comb begin
        tgt_req_o        = '0;
        core.data_gnt    = 1'b0;
        core.data_rvalid = 1'b0;
        core.data_rdata  = '0;
        push             = 1'b0;
        pop              = 1'b0;
        violation        = 1'b0;

        if (core.data_req && !stall) begin
            if (sel == SEL_LOCAL) begin
                core.data_gnt = 1'b1;
            end else begin
                for (int k = 0; k < 3; k++) begin
                    if (sel == 2'(k)) begin
                        tgt_req_o[k]  = 1'b1;
                        core.data_gnt = tgt_gnt_i[k];
                    end
                end
            end
        end
        push = core.data_gnt;

        if (!empty) begin
            if (head == SEL_LOCAL) begin
                core.data_rvalid = 1'b1;
                pop              = 1'b1;
            end else begin
                for (int k = 0; k < 3; k++) begin
                    if (head == 2'(k) && tgt_r_valid_i[k]) begin
                        core.data_rvalid = 1'b1;
                        core.data_rdata  = tgt_r_data_i[k];
                        pop              = 1'b1;
                    end
                end
            end
        end

        // A response from a target that is not at the head is dropped, never forwarded.
        for (int k = 0; k < 3; k++) begin
            if (tgt_r_valid_i[k] && (empty || head != 2'(k))) violation = 1'b1;
        end

        // Outputs read as their reset values the moment reset asserts.
        if (!rst_ni) begin
            tgt_req_o        = '0;
            core.data_gnt    = 1'b0;
            core.data_rvalid = 1'b0;
            core.data_rdata  = '0;
            push             = 1'b0;
            pop              = 1'b0;
            violation        = 1'b0;
        end
    end

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            tgt_add_o[k]  = (k == 2) ? {8'h00, core.data_addr[23:0]} : core.data_addr;
            tgt_wen_o[k]  = ~core.data_we;
            tgt_be_o[k]   = core.data_be;
            tgt_data_o[k] = core.data_wdata;
            if (!rst_ni) begin
                tgt_add_o[k]  = '0;
                tgt_wen_o[k]  = 1'b1;
                tgt_be_o[k]   = '0;
                tgt_data_o[k] = '0;
            end
        end
    end

    always_comb begin
        fifo_d = fifo_q;
        if (push) fifo_d[wr_ptr_q] = sel;
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        protocol_err_d = protocol_err_q | violation;
        exit_valid_d   = exit_valid_q;
        exit_code_d    = exit_code_q;
        putc_valid_d   = push && is_putc;
        putc_char_d    = putc_char_q;
        if (push && is_exit) begin
            exit_valid_d = 1'b1;
            exit_code_d  = core.data_wdata;
        end
        if (push && is_putc) putc_char_d = core.data_wdata[7:0];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(MAX_OUTSTANDING); i++) fifo_q[i] <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            protocol_err_q <= 1'b0;
            exit_valid_q   <= 1'b0;
            exit_code_q    <= '0;
            putc_valid_q   <= 1'b0;
            putc_char_q    <= '0;
        end else begin
            fifo_q         <= fifo_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            protocol_err_q <= protocol_err_d;
            exit_valid_q   <= exit_valid_d;
            exit_code_q    <= exit_code_d;
            putc_valid_q   <= putc_valid_d;
            putc_char_q    <= putc_char_d;
        end
    end

    assign core.data_err  = 1'b0;
    assign exit_valid_o   = exit_valid_q;
    assign exit_code_o    = exit_code_q;
    assign putc_valid_o   = putc_valid_q;
    assign putc_char_o    = putc_char_q;
    assign protocol_err_o = protocol_err_q;
endmodule

// File: tb/tb_tb_core_bus_router.sv
// Bench for the core data-bus router: directed transactions with an in-order
// expected-response queue checked whenever the router returns rvalid.
module tb_tb_core_bus_router;
    logic             clk;
    logic             rst_ni;
    logic [2:0]       tgt_req;
    logic [2:0][31:0] tgt_add;
    logic [2:0]       tgt_wen;
    logic [2:0][3:0]  tgt_be;
    logic [2:0][31:0] tgt_data;
    logic [2:0]       tgt_gnt;
    logic [2:0][31:0] tgt_r_data;
    logic [2:0]       tgt_r_valid;
    logic             exit_valid;
    logic [31:0]      exit_code;
    logic             putc_valid;
    logic [7:0]       putc_char;
    logic             protocol_err;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    tb_core_bus_router_if bus ();

    tb_core_bus_router dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .core           (bus.slave),
        .tgt_req_o      (tgt_req),
        .tgt_add_o      (tgt_add),
        .tgt_wen_o      (tgt_wen),
        .tgt_be_o       (tgt_be),
        .tgt_data_o     (tgt_data),
        .tgt_gnt_i      (tgt_gnt),
        .tgt_r_data_i   (tgt_r_data),
        .tgt_r_valid_i  (tgt_r_valid),
        .exit_valid_o   (exit_valid),
        .exit_code_o    (exit_code),
        .putc_valid_o   (putc_valid),
        .putc_char_o    (putc_char),
        .protocol_err_o (protocol_err)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Driver: apply one cycle of core request plus target responses, return mid-cycle.
    task automatic drive(input logic req, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [2:0] rv,
                         input logic [31:0] rdata_v);
        @(posedge clk);
        #1;
        bus.data_req   = req;
        bus.data_we    = we;
        bus.data_addr  = addr;
        bus.data_wdata = wdata;
        bus.data_be    = 4'(($urandom_range(0, 15)));
        tgt_r_valid    = rv;
        tgt_r_data     = {3{rdata_v}};
        @(negedge clk);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 32'h0);
    endtask

    // Scoreboard: every response the router returns must match the oldest expectation.
    always @(negedge clk) begin
        if (bus.data_rvalid) begin
            if (exp_q.size() == 0) begin
                check("rvalid_unexpected", 32'(bus.data_rvalid), 32'h0);
            end else begin
                check("rdata", bus.data_rdata, exp_q.pop_front());
            end
        end
    end

    initial begin
        logic [31:0] d1, d2, d3;
        rst_ni         = 1'b0;
        bus.data_req   = 1'b1;
        bus.data_we    = 1'b0;
        bus.data_addr  = 32'h0000_1000;
        bus.data_wdata = 32'h1234_5678;
        bus.data_be    = 4'hF;
        tgt_gnt        = 3'b111;
        tgt_r_valid    = 3'b000;
        tgt_r_data     = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_gnt", 32'(bus.data_gnt), 32'h0);
        check("rst_rvalid", 32'(bus.data_rvalid), 32'h0);
        check("rst_tgt_req", 32'(tgt_req), 32'h0);
        check("rst_tgt_wen", 32'(tgt_wen), 32'h7);
        check("rst_tgt_add1", tgt_add[1], 32'h0);
        check("rst_exit_valid", 32'(exit_valid), 32'h0);
        check("rst_putc_valid", 32'(putc_valid), 32'h0);
        check("rst_protocol_err", 32'(protocol_err), 32'h0);
        bus.data_req = 1'b0;
        rst_ni = 1'b1;

        // Stack read, response one cycle after grant
        drive(1'b1, 1'b0, 32'h0000_1000, 32'h0, 3'b000, 32'h0);
        check("stack_tgt_req", 32'(tgt_req), 32'h2);
        check("stack_gnt", 32'(bus.data_gnt), 32'h1);
        check("stack_rvalid_early", 32'(bus.data_rvalid), 32'h0);
        exp_q.push_back(32'hDEAD_BEEF);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 3'b010, 32'hDEAD_BEEF);
        check("stack_rvalid", 32'(bus.data_rvalid), 32'h1);

        // TCDM write with address remap
        drive(1'b1, 1'b1, 32'h1C01_0040, 32'(($urandom_range(0, 32'hFFFF))), 3'b000, 32'h0);
        check("tcdm_tgt_req", 32'(tgt_req), 32'h4);
        check("tcdm_add", tgt_add[2], 32'h0001_0040);
        check("tcdm_wen", 32'(tgt_wen[2]), 32'h0);
        check("tcdm_be", 32'(tgt_be[2]), 32'(bus.data_be));
        exp_q.push_back(32'h0);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 3'b100, 32'h0);

        // HWPE write keeps the full address
        drive(1'b1, 1'b1, 32'h0010_0008, 32'hA5A5_0001, 3'b000, 32'h0);
        check("hwpe_tgt_req", 32'(tgt_req), 32'h1);
        check("hwpe_add", tgt_add[0], 32'h0010_0008);
        check("hwpe_data", tgt_data[0], 32'hA5A5_0001);
        exp_q.push_back(32'h0000_0011);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 3'b001, 32'h0000_0011);

        // Out-of-order response: target 0 answers before target 2
        drive(1'b1, 1'b0, 32'h1C00_0000, 32'h0, 3'b000, 32'h0);
        drive(1'b1, 1'b0, 32'h0010_0000, 32'h0, 3'b000, 32'h0);
        check("ooo_gnt2", 32'(bus.data_gnt), 32'h1);
        exp_q.push_back(32'hCAFE_0002);
        exp_q.push_back(32'h0000_A0A0);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 3'b001, 32'hBAD0_0000);
        check("ooo_dropped", 32'(bus.data_rvalid), 32'h0);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 3'b100, 32'hCAFE_0002);
        check("ooo_protocol_err", 32'(protocol_err), 32'h1);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 3'b001, 32'h0000_A0A0);
        check("ooo_err_pulse", 32'(bus.data_err), 32'h0);

        // Stall at MAX_OUTSTANDING, no same-cycle pop bypass
        d1 = $urandom_range(1, 32'h7FFF_FFFF);
        d2 = $urandom_range(1, 32'h7FFF_FFFF);
        d3 = $urandom_range(1, 32'h7FFF_FFFF);
        drive(1'b1, 1'b0, 32'h0000_2000, 32'h0, 3'b000, 32'h0);
        exp_q.push_back(d1);
        drive(1'b1, 1'b0, 32'h0000_2004, 32'h0, 3'b000, 32'h0);
        exp_q.push_back(d2);
        drive(1'b1, 1'b0, 32'h0000_2008, 32'h0, 3'b000, 32'h0);
        check("stall_gnt", 32'(bus.data_gnt), 32'h0);
        check("stall_tgt_req", 32'(tgt_req), 32'h0);
        drive(1'b1, 1'b0, 32'h0000_2008, 32'h0, 3'b010, d1);
        check("stall_no_bypass", 32'(bus.data_gnt), 32'h0);
        drive(1'b1, 1'b0, 32'h0000_2008, 32'h0, 3'b000, 32'h0);
        check("stall_release_gnt", 32'(bus.data_gnt), 32'h1);
        check("stall_release_req", 32'(tgt_req), 32'h2);
        exp_q.push_back(d3);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 3'b010, d2);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 3'b010, d3);

        // MMIO putchar then exit
        drive(1'b1, 1'b1, 32'h8000_0004, 32'h1234_5641, 3'b000, 32'h0);
        check("putc_gnt", 32'(bus.data_gnt), 32'h1);
        check("putc_tgt_req", 32'(tgt_req), 32'h0);
        exp_q.push_back(32'h0);
        drive(1'b1, 1'b1, 32'h8000_0000, 32'h0, 3'b000, 32'h0);
        check("putc_valid", 32'(putc_valid), 32'h1);
        check("putc_char", 32'(putc_char), 32'h41);
        check("putc_local_rvalid", 32'(bus.data_rvalid), 32'h1);
        exp_q.push_back(32'h0);
        idle();
        check("putc_pulse_end", 32'(putc_valid), 32'h0);
        check("exit_valid", 32'(exit_valid), 32'h1);
        check("exit_code", exit_code, 32'h0);
        drive(1'b1, 1'b1, 32'h8000_0000, 32'h0000_002A, 3'b000, 32'h0);
        exp_q.push_back(32'h0);
        idle();
        check("exit_overwrite", exit_code, 32'h0000_002A);

        // MMIO address read goes to TCDM
        drive(1'b1, 1'b0, 32'h8000_0000, 32'h0, 3'b000, 32'h0);
        check("mmio_read_req", 32'(tgt_req), 32'h4);
        check("mmio_read_add", tgt_add[2], 32'h0);
        exp_q.push_back(32'h5555_AAAA);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 3'b100, 32'h5555_AAAA);

        // Reset with a read in flight
        drive(1'b1, 1'b0, 32'h0000_3000, 32'h0, 3'b000, 32'h0);
        check("midrst_gnt", 32'(bus.data_gnt), 32'h1);
        @(posedge clk);
        #2;
        rst_ni = 1'b0;
        #1;
        check("midrst_gnt_low", 32'(bus.data_gnt), 32'h0);
        check("midrst_tgt_req", 32'(tgt_req), 32'h0);
        check("midrst_tgt_wen", 32'(tgt_wen), 32'h7);
        check("midrst_protocol_err", 32'(protocol_err), 32'h0);
        check("midrst_exit_valid", 32'(exit_valid), 32'h0);
        check("midrst_exit_code", exit_code, 32'h0);
        @(negedge clk);
        bus.data_req = 1'b0;
        @(negedge clk);
        rst_ni = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 3'b010, 32'h0000_0077);
        check("postrst_no_rvalid", 32'(bus.data_rvalid), 32'h0);
        idle();
        check("postrst_protocol_err", 32'(protocol_err), 32'h1);

        repeat (2) idle();
        check("exp_q_drained", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
